// File: rtl/nx_node_exec.sv
// nx_node_exec: runs one mesh node's truth-table program in hardware.
// The program is streamed into a small instruction store. Each trigger snapshots
// node_in, executes one instruction per cycle, and then commits every node output
// at once.
module nx_node_exec #(
  parameter int INSTR_DEPTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ld_valid,
  output logic                               ld_ready,
  input  logic [26:0]                        ld_data,
  input  logic                               ld_last,
  input  logic                               trigger,
  input  logic [7:0]                         node_in,
  output logic [7:0]                         node_out,
  output logic                               busy,
  output logic                               done,
  output logic                               prog_valid,
  output logic [$clog2(INSTR_DEPTH+1)-1:0]   instr_count,
  output logic                               ld_overflow
);

  localparam int CW = $clog2(INSTR_DEPTH + 1);
  localparam int PW = (INSTR_DEPTH > 1) ? $clog2(INSTR_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_next;

  // The store has no reset; after a reset its contents are never read until a
  // new program has been loaded.
  logic [26:0]   store [INSTR_DEPTH];
  logic [CW-1:0] wptr;
  logic          prog_open;
  logic [PW-1:0] pc;
  logic [7:0]    in_q;
  logic [7:0]    regs;
  logic [7:0]    out_next;

  // Load-side decode. The first word of a new program starts writing at slot 0.
  logic          ld_fire;
  logic [CW-1:0] base_ptr;
  logic          store_full;
  logic [CW-1:0] wptr_after;

  assign ld_ready   = (state == IDLE) && !trigger;
  assign ld_fire    = ld_valid && ld_ready;
  assign base_ptr   = prog_open ? wptr : '0;
  assign store_full = (base_ptr == CW'(INSTR_DEPTH));
  assign wptr_after = store_full ? base_ptr : base_ptr + CW'(1);

  // Execute-side decode of the instruction at pc.
  logic [26:0] instr;
  logic [7:0]  truth;
  logic [2:0]  src_a, src_b, src_c, tgt_reg, out_idx;
  logic        a_ip, b_ip, c_ip, out_en;
  logic        op_a, op_b, op_c, result;
  logic        start, last_step;

  assign instr   = store[pc];
  assign truth   = instr[26:19];
  assign a_ip    = instr[18];
  assign src_a   = instr[17:15];
  assign b_ip    = instr[14];
  assign src_b   = instr[13:11];
  assign c_ip    = instr[10];
  assign src_c   = instr[9:7];
  assign tgt_reg = instr[6:4];
  assign out_en  = instr[3];
  assign out_idx = instr[2:0];

  assign op_a   = a_ip ? in_q[src_a] : regs[src_a];
  assign op_b   = b_ip ? in_q[src_b] : regs[src_b];
  assign op_c   = c_ip ? in_q[src_c] : regs[src_c];
  assign result = truth[{op_a, op_b, op_c}];

  assign start     = (state == IDLE) && trigger && prog_valid && (instr_count != '0);
  assign last_step = (CW'(pc) == (instr_count - CW'(1)));
  assign busy      = (state != IDLE);

  // Instruction store write port; words beyond the store depth are dropped.
  always_ff @(posedge clk) begin
    if (ld_fire && !store_full) begin
      store[base_ptr[PW-1:0]] <= ld_data;
    end
  end

  // Program bookkeeping: write pointer, completion, length and the overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      prog_open   <= 1'b0;
      prog_valid  <= 1'b0;
      instr_count <= '0;
      ld_overflow <= 1'b0;
    end else if (ld_fire) begin
      wptr        <= wptr_after;
      ld_overflow <= (prog_open ? ld_overflow : 1'b0) | store_full;
      if (ld_last) begin
        prog_valid  <= 1'b1;
        instr_count <= wptr_after;
        prog_open   <= 1'b0;
      end else begin
        prog_valid  <= 1'b0;
        prog_open   <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one EXEC cycle per instruction, then a single COMMIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXEC;
      EXEC:    if (last_step) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Evaluation datapath: snapshot and clear on start, then one instruction per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q     <= '0;
      regs     <= '0;
      out_next <= '0;
      pc       <= '0;
    end else if (start) begin
      in_q     <= node_in;
      regs     <= '0;
      out_next <= '0;
      pc       <= '0;
    end else if (state == EXEC) begin
      regs[tgt_reg] <= result;
      if (out_en) begin
        out_next[out_idx] <= result;
      end
      if (!last_step) begin
        pc <= pc + PW'(1);
      end
    end
  end

  // Atomic output commit with a one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == COMMIT);
      if (state == COMMIT) begin
        node_out <= out_next;
      end
    end
  end

endmodule

// File: tb/tb_nx_node_exec.sv
// tb_nx_node_exec: directed test of nx_node_exec with a 4-deep instruction store.
// Each run pushes its hand-computed result onto a queue; a monitor pops and
// compares whenever done is presented.
module tb_nx_node_exec;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [26:0] ld_data;
  logic        ld_last;
  logic        trigger;
  logic [7:0]  node_in;
  logic [7:0]  node_out;
  logic        busy;
  logic        done;
  logic        prog_valid;
  logic [2:0]  instr_count;
  logic        ld_overflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  nx_node_exec #(.INSTR_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .trigger     (trigger),
    .node_in     (node_in),
    .node_out    (node_out),
    .busy        (busy),
    .done        (done),
    .prog_valid  (prog_valid),
    .instr_count (instr_count),
    .ld_overflow (ld_overflow)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [26:0] mk(input logic [7:0] truth,
                                     input logic aip, input logic [2:0] sa,
                                     input logic bip, input logic [2:0] sb,
                                     input logic cip, input logic [2:0] sc,
                                     input logic [2:0] tgt,
                                     input logic oen, input logic [2:0] oidx);
    return {truth, aip, sa, bip, sb, cip, sc, tgt, oen, oidx};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got node_out 0x%0h, expected no done", node_out);
      end else begin
        checkOutput("node_out", {24'd0, node_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Load one instruction word through the valid/ready port (bounded wait).
  task automatic applyStimulus(input logic [26:0] w, input logic last);
    int n;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = w;
    ld_last  = last;
    #1;
    n = 0;
    while (!ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      checkOutput("ld_ready_timeout", 32'(ld_ready), 32'd1);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // One run: trigger, optionally toggle node_in and re-trigger while busy, then
  // check the busy length and done latency.
  task automatic run_prog(input string tag, input logic [7:0] din, input logic [7:0] expv,
                          input int n, input logic toggle, input logic poke);
    int first_done;
    int busy_cnt;
    int done_cnt;
    first_done = -1;
    busy_cnt   = 0;
    done_cnt   = 0;
    @(negedge clk);
    node_in = din;
    trigger = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    trigger = 1'b0;
    for (int idx = 0; idx < n + 4; idx++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = idx;
      end
      if (toggle && idx < n) node_in = node_in ^ 8'hFF;
      trigger = (poke && idx == 2);
      @(negedge clk);
    end
    trigger = 1'b0;
    checkOutput({tag, "_done_latency"}, 32'(first_done), 32'(n + 1));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n + 1));
    checkOutput({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  // A trigger that must be ignored: ld_ready drops, but no run starts.
  task automatic pulse_ignored(input string tag);
    @(negedge clk);
    trigger = 1'b1;
    #1;
    checkOutput({tag, "_ld_ready_low"}, 32'(ld_ready), 32'd0);
    @(negedge clk);
    trigger = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      @(negedge clk);
    end
  endtask

  logic [26:0] maj;
  logic [26:0] ch0, ch1;
  logic [26:0] s0, s1, s2, s3;
  logic [26:0] o0, o1, o2, o3, o4, o5;

  initial begin
    // Majority of in0..in2 written to out5.
    maj = mk(8'hE8, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 3'd2, 3'd0, 1'b1, 3'd5);
    // r2 = in0 & in1; out0 = r2 ^ in2 ^ r0 (r0 is cleared at start).
    ch0 = mk(8'hC0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 3'd0, 3'd2, 1'b0, 3'd0);
    ch1 = mk(8'h96, 1'b0, 3'd2, 1'b1, 3'd2, 1'b0, 3'd0, 3'd3, 1'b1, 3'd0);
    // r1 = in3 & in4; out1 = in5; out7 = !r1; out2 = r1 | in6.
    s0 = mk(8'hC0, 1'b1, 3'd3, 1'b1, 3'd4, 1'b1, 3'd3, 3'd1, 1'b0, 3'd0);
    s1 = mk(8'hF0, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd5, 3'd4, 1'b1, 3'd1);
    s2 = mk(8'h0F, 1'b0, 3'd1, 1'b0, 3'd1, 1'b0, 3'd1, 3'd5, 1'b1, 3'd7);
    s3 = mk(8'hFC, 1'b0, 3'd1, 1'b1, 3'd6, 1'b0, 3'd1, 3'd6, 1'b1, 3'd2);
    // out0 = in0 then out0 = !in0 (second wins); out3 = in1; out4 = 1;
    // the two dropped words would set out6 and out7.
    o0 = mk(8'hF0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0);
    o1 = mk(8'h0F, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0);
    o2 = mk(8'hF0, 1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd1, 3'd0, 1'b1, 3'd3);
    o3 = mk(8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd4);
    o4 = mk(8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd6);
    o5 = mk(8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd7);

    rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    trigger = 1'b0; node_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_node_out", 32'(node_out), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_prog_valid", 32'(prog_valid), 32'd0);
    checkOutput("rst_instr_count", 32'(instr_count), 32'd0);
    checkOutput("rst_ld_overflow", 32'(ld_overflow), 32'd0);
    checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);

    $display("[TB] trigger without program");
    pulse_ignored("trig_no_prog");
    checkOutput("no_prog_node_out", 32'(node_out), 32'd0);

    $display("[TB] majority");
    applyStimulus(maj, 1'b1);
    checkOutput("maj_instr_count", 32'(instr_count), 32'd1);
    checkOutput("maj_prog_valid", 32'(prog_valid), 32'd1);
    run_prog("maj", 8'h03, 8'h20, 1, 1'b0, 1'b0);

    $display("[TB] register chaining with trigger mid-load");
    applyStimulus(ch0, 1'b0);
    checkOutput("midload_prog_valid", 32'(prog_valid), 32'd0);
    pulse_ignored("trig_mid_load");
    applyStimulus(ch1, 1'b1);
    checkOutput("chain_instr_count", 32'(instr_count), 32'd2);
    run_prog("chain_07", 8'h07, 8'h00, 2, 1'b0, 1'b0);
    run_prog("chain_03", 8'h03, 8'h01, 2, 1'b0, 1'b0);

    $display("[TB] snapshot");
    applyStimulus(s0, 1'b0);
    applyStimulus(s1, 1'b0);
    applyStimulus(s2, 1'b0);
    applyStimulus(s3, 1'b1);
    checkOutput("snap_instr_count", 32'(instr_count), 32'd4);
    run_prog("snap_18", 8'h18, 8'h04, 4, 1'b1, 1'b1);
    run_prog("snap_60", 8'h60, 8'h86, 4, 1'b1, 1'b0);

    $display("[TB] overflow");
    applyStimulus(o0, 1'b0);
    applyStimulus(o1, 1'b0);
    applyStimulus(o2, 1'b0);
    applyStimulus(o3, 1'b0);
    checkOutput("ovf_before_drop", 32'(ld_overflow), 32'd0);
    applyStimulus(o4, 1'b0);
    applyStimulus(o5, 1'b1);
    checkOutput("ovf_flag", 32'(ld_overflow), 32'd1);
    checkOutput("ovf_instr_count", 32'(instr_count), 32'd4);
    checkOutput("ovf_prog_valid", 32'(prog_valid), 32'd1);
    run_prog("ovf_01", 8'h01, 8'h10, 4, 1'b0, 1'b0);
    run_prog("ovf_02", 8'h02, 8'h19, 4, 1'b0, 1'b0);

    $display("[TB] reload");
    applyStimulus(maj, 1'b1);
    checkOutput("reload_instr_count", 32'(instr_count), 32'd1);
    checkOutput("reload_ld_overflow", 32'(ld_overflow), 32'd0);
    run_prog("reload", 8'h05, 8'h20, 1, 1'b0, 1'b0);

    $display("[TB] async reset mid-run");
    applyStimulus(s0, 1'b0);
    applyStimulus(s1, 1'b0);
    applyStimulus(s2, 1'b0);
    applyStimulus(s3, 1'b1);
    @(negedge clk);
    node_in = 8'h18;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_node_out", 32'(node_out), 32'd0);
    checkOutput("arst_prog_valid", 32'(prog_valid), 32'd0);
    checkOutput("arst_instr_count", 32'(instr_count), 32'd0);
    checkOutput("arst_ld_overflow", 32'(ld_overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_ignored("trig_after_rst");
    checkOutput("after_rst_node_out", 32'(node_out), 32'd0);
    applyStimulus(maj, 1'b1);
    run_prog("post_rst", 8'h07, 8'h20, 1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
